// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if: fetch-stage bus carrying the decode handshake, redirect and program load signals
//   master: drives pc_src, branch_target, out_ready, load_en, load_addr, load_data
//   slave : drives out_valid, instruction, instr_pc, fetch_pc
interface ifetch_prefetch_if #(
  parameter int WORD        = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_DEPTH  = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic                   pc_src;
  logic [WORD-1:0]        branch_target;
  logic                   out_ready;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [WORD-1:0]        instr_pc;
  logic [WORD-1:0]        fetch_pc;
  logic                   load_en;
  logic [AW-1:0]          load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  modport master (
    output pc_src, branch_target, out_ready, load_en, load_addr, load_data,
    input  out_valid, instruction, instr_pc, fetch_pc
  );
  modport slave (
    input  pc_src, branch_target, out_ready, load_en, load_addr, load_data,
    output out_valid, instruction, instr_pc, fetch_pc
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction fetch with PC, instruction memory and a small {pc, instr} prefetch FIFO
//   clk, rst_n (async active-low); bus (slave): redirect in, decode valid/ready out, program load in
module ifetch_prefetch #(
  parameter int              WORD        = 64,
  parameter int              INSTR_WIDTH = 32,
  parameter int              IMEM_DEPTH  = 64,
  parameter int              QUEUE_DEPTH = 2,
  parameter logic [WORD-1:0] RESET_PC    = '0
) (
  input logic               clk,
  input logic               rst_n,
  ifetch_prefetch_if.slave  bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] FULL = (QW+1)'(QUEUE_DEPTH);
  logic [INSTR_WIDTH-1:0] imem  [IMEM_DEPTH];
  logic [WORD-1:0]        q_pc  [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] q_ins [QUEUE_DEPTH];
  logic [QW-1:0]          head, tail;
  logic [QW:0]            count;
  logic [WORD-1:0]        pc;
  logic                   valid, deq, enq;
  assign valid           = count != '0;
  assign deq             = valid & bus.out_ready;
  // a full queue still takes a fetch when its head leaves in the same cycle
  assign enq             = !bus.pc_src & (count < FULL | deq);
  assign bus.out_valid   = valid;
  assign bus.instruction = valid ? q_ins[head] : '0;
  assign bus.instr_pc    = valid ? q_pc[head] : '0;
  assign bus.fetch_pc    = pc;
  // imem read is combinational, so a same-cycle load is seen by fetch only from the next cycle
  always_ff @(posedge clk)
    if (bus.load_en) imem[bus.load_addr] <= bus.load_data;
  always_ff @(posedge clk)
    if (enq) begin
      q_pc[tail]  <= pc;
      q_ins[tail] <= imem[pc[AW+1:2]];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= RESET_PC;
    end else if (bus.pc_src) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= bus.branch_target & ~WORD'(3);
    end else begin
      head  <= head + QW'(deq);
      tail  <= tail + QW'(enq);
      count <= count + (QW+1)'(enq) - (QW+1)'(deq);
      if (enq) pc <= pc + WORD'(4);
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: vector table, corner-case sequences and random stimulus against a queue-based model
module tb_ifetch_prefetch;
  localparam int QD = 2;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  typedef struct {
    bit          ps;
    logic [63:0] tgt;
    bit          rdy;
    bit          v;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] fpc;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mm [64];
  ent_t        mq [$];
  logic [63:0] mpc;
  vec_t        tv [7];
  ifetch_prefetch_if #(.WORD(64), .INSTR_WIDTH(32), .IMEM_DEPTH(64)) bus ();
  ifetch_prefetch #(.WORD(64), .INSTR_WIDTH(32), .IMEM_DEPTH(64), .QUEUE_DEPTH(QD), .RESET_PC(64'd0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: inputs at the edge decide pop / flush / fetch; loads land after the fetch read
  task automatic model_edge();
    logic [31:0] rd;
    rd = mm[mpc[7:2]];
    if (bus.pc_src) begin
      mq.delete();
      mpc = bus.branch_target & ~64'd3;
    end else begin
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (mq.size() < QD) begin
        mq.push_back('{pc: mpc, ins: rd});
        mpc = mpc + 64'd4;
      end
    end
    if (bus.load_en) mm[bus.load_addr] = bus.load_data;
  endtask

  task automatic cmp_model();
    check("model_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    check("model_instr_pc", bus.instr_pc, mq.size() != 0 ? mq[0].pc : 64'd0);
    check("model_instruction", 64'(bus.instruction), mq.size() != 0 ? 64'(mq[0].ins) : 64'd0);
    check("model_fetch_pc", bus.fetch_pc, mpc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic head_is(input string name, input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] fpc);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_pc"}, bus.instr_pc, pc);
    check({name, "_instr"}, 64'(bus.instruction), 64'(ins));
    check({name, "_fetch_pc"}, bus.fetch_pc, fpc);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 0;
    #2 rst_n = 1;
    mq.delete();
    mpc = 0;
  endtask

  initial begin
    logic [31:0] prog [64];
    bus.pc_src = 0;
    bus.branch_target = 0;
    bus.out_ready = 0;
    bus.load_en = 0;
    bus.load_addr = 0;
    bus.load_data = 0;
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
    prog[0]  = 32'hF8400001;
    prog[1]  = 32'h8B020023;
    prog[2]  = 32'hCB040065;
    prog[3]  = 32'hB4000040;
    prog[16] = 32'h17FFFFFC;
    prog[63] = 32'hAAAA0001;
    tv[0] = '{0, 64'd0,    1, 1, 64'd0,    32'hF8400001, 64'd4};
    tv[1] = '{0, 64'd0,    1, 1, 64'd4,    32'h8B020023, 64'd8};
    tv[2] = '{0, 64'd0,    1, 1, 64'd8,    32'hCB040065, 64'd12};
    tv[3] = '{0, 64'd0,    1, 1, 64'd12,   32'hB4000040, 64'd16};
    tv[4] = '{1, 64'h43,   1, 0, 64'd0,    32'h0,        64'h40};
    tv[5] = '{0, 64'd0,    1, 1, 64'h40,   32'h17FFFFFC, 64'h44};
    tv[6] = '{0, 64'd0,    0, 1, 64'h40,   32'h17FFFFFC, 64'h48};
    // program load while held in reset
    for (int i = 0; i < 64; i++) begin
      bus.load_en = 1;
      bus.load_addr = 6'(i);
      bus.load_data = prog[i];
      @(posedge clk);
      #1;
    end
    bus.load_en = 0;
    mm = prog;
    mq.delete();
    mpc = 0;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_fetch_pc", bus.fetch_pc, 64'd0);
    check("rst_instr", 64'(bus.instruction), 64'd0);
    check("rst_instr_pc", bus.instr_pc, 64'd0);
    rst_n = 1;
    // streaming fetch, then a misaligned redirect
    for (int i = 0; i < 7; i++) begin
      bus.pc_src = tv[i].ps;
      bus.branch_target = tv[i].tgt;
      bus.out_ready = tv[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tv[i].v));
      check($sformatf("vec%0d_fetch_pc", i), bus.fetch_pc, tv[i].fpc);
      if (tv[i].v) begin
        check($sformatf("vec%0d_pc", i), bus.instr_pc, tv[i].pc);
        check($sformatf("vec%0d_instr", i), 64'(bus.instruction), 64'(tv[i].ins));
      end
    end
    // backpressure: queue fills to two and fetch freezes at 8
    reset_pulse();
    bus.pc_src = 0;
    bus.out_ready = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i >= 1) head_is("stall", 64'd0, 32'hF8400001, 64'd8);
    end
    bus.out_ready = 1;
    tick();
    head_is("unstall", 64'd4, 32'h8B020023, 64'd12);
    bus.out_ready = 0;
    tick();
    // asynchronous reset between edges with a full queue
    #3 rst_n = 0;
    #1;
    check("async_valid", 64'(bus.out_valid), 64'd0);
    check("async_fetch_pc", bus.fetch_pc, 64'd0);
    check("async_instr", 64'(bus.instruction), 64'd0);
    check("async_instr_pc", bus.instr_pc, 64'd0);
    #2 rst_n = 1;
    mq.delete();
    mpc = 0;
    tick();
    head_is("restart", 64'd0, 32'hF8400001, 64'd4);
    // redirect near the end of imem: index wraps to 0
    bus.pc_src = 1;
    bus.branch_target = 64'hFC;
    bus.out_ready = 1;
    tick();
    check("wrap_flush_valid", 64'(bus.out_valid), 64'd0);
    check("wrap_flush_fetch_pc", bus.fetch_pc, 64'hFC);
    bus.pc_src = 0;
    tick();
    head_is("wrap_a", 64'hFC, 32'hAAAA0001, 64'h100);
    tick();
    head_is("wrap_b", 64'h100, 32'hF8400001, 64'h104);
    // load into the index being fetched in the same cycle
    reset_pulse();
    tick();
    tick();
    bus.load_en = 1;
    bus.load_addr = 6'd2;
    bus.load_data = 32'h12345678;
    tick();
    head_is("collide_old", 64'd8, 32'hCB040065, 64'd12);
    bus.load_en = 0;
    bus.pc_src = 1;
    bus.branch_target = 64'd8;
    tick();
    bus.pc_src = 0;
    tick();
    head_is("collide_new", 64'd8, 32'h12345678, 64'd12);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.pc_src = ($urandom_range(0, 7) == 0);
      bus.branch_target = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 511));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.load_en = ($urandom_range(0, 9) == 0);
      bus.load_addr = 6'($urandom_range(0, 63));
      bus.load_data = $urandom;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction-fetch stage with a small prefetch queue.
- Owns the program counter and the instruction memory.
- Delivers {pc, instruction} pairs to decode through a valid/ready handshake.
- Consumes pc_src and branch_target from the memory stage to redirect fetch and flush stale prefetched instructions.

Parameters:
WORD, 64, PC/address width in bits
INSTR_WIDTH, 32, instruction width in bits
IMEM_DEPTH, 64, instruction memory depth in words (power of 2)
QUEUE_DEPTH, 2, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_src  in  1  redirect request from memory stage
branch_target  in  WORD  redirect address, used when pc_src=1
out_ready  in  1  decode accepts head entry this cycle
out_valid  out  1  head entry present
instruction  out  INSTR_WIDTH  head entry instruction
instr_pc  out  WORD  head entry PC
fetch_pc  out  WORD  PC of next word to be fetched
load_en  in  1  imem write strobe (program load)
load_addr  in  log2(IMEM_DEPTH)  imem word index for load
load_data  in  INSTR_WIDTH  imem write data

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n=0: fetch_pc=RESET_PC, queue count=0, out_valid=0, instruction=0, instr_pc=0. This takes effect immediately, including mid-operation.
- imem contents are NOT cleared by reset.

imem:
- Combinational read at index fetch_pc[log2(IMEM_DEPTH)+1:2].
- Address wraps modulo IMEM_DEPTH words; bits above the index and bits [1:0] are ignored for the read.
- Synchronous write when load_en=1.
- Same-cycle fetch read and load write to the same index: the fetch sees the old data; the new data is visible from the next cycle.

Queue:
- FIFO of {pc, instr} with count 0..QUEUE_DEPTH.
- out_valid = (count != 0). instruction and instr_pc come from the head; both are 0 when the queue is empty.
- deq = out_valid & out_ready.
- enq = !pc_src & (count < QUEUE_DEPTH | deq). A full queue accepts a fetch in the same cycle the head is consumed.
- On enq: write {fetch_pc, imem[index]} to the tail and set fetch_pc <= fetch_pc + 4 (modulo 2^WORD).
- count' = count + enq - deq.
- With no enq, fetch_pc holds.

Redirect (pc_src=1 at an edge):
- Priority over everything else.
- Queue flushed: count <= 0. A deq completing that cycle is still a completed handshake for decode.
- No enqueue that cycle.
- fetch_pc <= {branch_target[WORD-1:2], 2'b00}; misaligned targets are forced word-aligned.
- Latency: out_valid=0 after edge N. The target instruction is valid after edge N+1, provided pc_src=0 at N+1.
- pc_src held high for several cycles: fetch stays stalled at the latest target.

Latency and throughput:
- After reset release, the first edge enqueues the RESET_PC word; out_valid=1 after that edge.
- Sustained throughput with out_ready=1 is one instruction per cycle.
- Pointers wrap modulo QUEUE_DEPTH.

Test Plan:
- Load imem[0..3]=32'hF8400001, 32'h8B020023, 32'hCB040065, 32'hB4000040; release reset; out_ready=1 -> after edges 1,2,3 the head is (pc 0, F8400001), (4, 8B020023), (8, CB040065); fetch_pc=12 after edge 3.
- Same program, out_ready=0 -> after edge 2 count=2 and fetch_pc=8 frozen; head stays (0, F8400001) for 5 cycles. Raise out_ready -> (4, 8B020023) the next cycle, and fetch resumes at 8 in the same cycle.
- Steady fetch, pc_src=1 with branch_target=0x40 for one edge (imem[16]=32'h17FFFFFC) -> out_valid=0 for one cycle, then head (0x40, 17FFFFFC); previously prefetched PCs 8/12 never appear.
- branch_target=0x43 -> fetch_pc=0x40 and the head pc is 0x40, not 0x43.
- Wrap: redirect to 0xFC with imem[63]=A, imem[0]=B -> heads (0xFC, A) then (0x100, B); fetch_pc continues 0x104.
- Assert rst_n=0 asynchronously between edges with count=2 -> out_valid=0 and fetch_pc=0 immediately, before the next edge. On release, fetch restarts at RESET_PC and imem contents are intact.
- Load imem[2]=X in the same cycle fetch reads index 2 (old value Y) -> the enqueued instr is Y; re-fetching PC 8 later returns X.
